// File: rtl/matriz_leds_varredura_if.sv
// Signal bundle between the display logic (master) and the LED-matrix scanner (slave).
// Carries the frame-store write port, swap/blink controls and the matrix pin drive.
interface matriz_leds_varredura_if #(
   parameter int unsigned N_LINHAS  = 7,
   parameter int unsigned N_COLUNAS = 5
) ();
   localparam int unsigned CW = (N_COLUNAS > 1) ? $clog2(N_COLUNAS) : 1;

   logic                 enable;
   logic                 wr_en;
   logic [CW-1:0]        wr_col;
   logic [N_LINHAS-1:0]  wr_data;
   logic                 swap_req;
   logic                 pisca;
   logic [N_LINHAS-1:0]  linhas;
   logic [N_COLUNAS-1:0] colunas;
   logic                 frame_fim;
   logic                 swap_pend;
   logic                 swap_feito;

   modport master (
      output enable, wr_en, wr_col, wr_data, swap_req, pisca,
      input  linhas, colunas, frame_fim, swap_pend, swap_feito
   );

   modport slave (
      input  enable, wr_en, wr_col, wr_data, swap_req, pisca,
      output linhas, colunas, frame_fim, swap_pend, swap_feito
   );
endinterface

// File: rtl/matriz_leds_varredura.sv
// Self-scanning LED-matrix driver: column-slot timer with blanking, double-buffered
// frame store swapped on frame boundaries, optional frame-counted blink.
module matriz_leds_varredura #(
   parameter int unsigned N_LINHAS          = 7,
   parameter int unsigned N_COLUNAS         = 5,
   parameter int unsigned DIV_TICKS         = 1000,
   parameter int unsigned BLANK_TICKS       = 2,
   parameter bit          LINHA_ATIVA_BAIXA = 1'b1,
   parameter int unsigned BLINK_FRAMES      = 32
) (
   input logic                      clk,
   input logic                      reset,
   matriz_leds_varredura_if.slave   bus
);
   localparam int unsigned CW = (N_COLUNAS > 1) ? $clog2(N_COLUNAS) : 1;
   localparam int unsigned TW = (DIV_TICKS > 1) ? $clog2(DIV_TICKS) : 1;
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [TW-1:0]       TICK_MAX   = TW'(DIV_TICKS - 1);
   localparam logic [TW-1:0]       TICK_BLANK = TW'(BLANK_TICKS);
   localparam logic [CW-1:0]       COL_MAX    = CW'(N_COLUNAS - 1);
   localparam logic [BW-1:0]       BLINK_ULT  = BW'(BLINK_FRAMES - 1);
   localparam logic [N_LINHAS-1:0] LINHAS_OFF = {N_LINHAS{LINHA_ATIVA_BAIXA}};

   logic [TW-1:0]        tick_q, tick_d;
   logic [CW-1:0]        col_q, col_d;
   logic                 sel_q, sel_d;
   logic                 pend_q, pend_d;
   logic [BW-1:0]        blink_q, blink_d;
   logic                 fase_q, fase_d;
   logic [N_LINHAS-1:0]  mem_q [2][N_COLUNAS];
   logic [N_LINHAS-1:0]  linhas_q, linhas_d;
   logic [N_COLUNAS-1:0] colunas_q, colunas_d;
   logic                 frame_fim_q, frame_fim_d;
   logic                 swap_feito_q, swap_feito_d;

   logic                 fim;
   logic                 aceso;
   logic                 wr_ok;
   logic [N_LINHAS-1:0]  frente;
   logic [N_LINHAS-1:0]  linhas_rev;

   assign wr_ok = bus.wr_en && (32'(bus.wr_col) < N_COLUNAS);

   always_comb begin
      tick_d       = tick_q;
      col_d        = col_q;
      sel_d        = sel_q;
      pend_d       = pend_q | bus.swap_req;
      blink_d      = blink_q;
      fase_d       = fase_q;
      swap_feito_d = 1'b0;
      fim          = bus.enable && (col_q == COL_MAX) && (tick_q == TICK_MAX);

      if (!bus.enable) begin
         tick_d = '0;
         col_d  = '0;
      end else if (tick_q == TICK_MAX) begin
         tick_d = '0;
         col_d  = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
      end else begin
         tick_d = tick_q + 1'b1;
      end

      // A request arriving in the frame-end cycle itself is honoured at that boundary.
      if (fim && pend_d) begin
         sel_d        = ~sel_q;
         pend_d       = 1'b0;
         swap_feito_d = 1'b1;
      end

      if (!bus.enable || !bus.pisca) begin
         blink_d = '0;
         fase_d  = 1'b1;
      end else if (fim) begin
         if (blink_q == BLINK_ULT) begin
            blink_d = '0;
            fase_d  = ~fase_q;
         end else begin
            blink_d = blink_q + 1'b1;
         end
      end
   end

   always_comb begin
      frente = mem_q[sel_q][col_q];
      for (int unsigned r = 0; r < N_LINHAS; r++) begin
         linhas_rev[r] = frente[N_LINHAS-1-r];
      end
      aceso       = bus.enable && !(bus.pisca && !fase_q) && (tick_q >= TICK_BLANK);
      colunas_d   = aceso ? (N_COLUNAS'(1) << col_q) : '0;
      linhas_d    = aceso ? (linhas_rev ^ LINHAS_OFF) : LINHAS_OFF;
      frame_fim_d = fim;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q       <= '0;
         col_q        <= '0;
         sel_q        <= 1'b0;
         pend_q       <= 1'b0;
         blink_q      <= '0;
         fase_q       <= 1'b1;
         mem_q        <= '{default: '0};
         linhas_q     <= LINHAS_OFF;
         colunas_q    <= '0;
         frame_fim_q  <= 1'b0;
         swap_feito_q <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         col_q        <= col_d;
         sel_q        <= sel_d;
         pend_q       <= pend_d;
         blink_q      <= blink_d;
         fase_q       <= fase_d;
         linhas_q     <= linhas_d;
         colunas_q    <= colunas_d;
         frame_fim_q  <= frame_fim_d;
         swap_feito_q <= swap_feito_d;
         // Back buffer is selected by the pre-swap sel, so a swap-cycle write hits the new front.
         if (wr_ok) begin
            mem_q[~sel_q][bus.wr_col] <= bus.wr_data;
         end
      end
   end

   assign bus.linhas     = linhas_q;
   assign bus.colunas    = colunas_q;
   assign bus.frame_fim  = frame_fim_q;
   assign bus.swap_pend  = pend_q;
   assign bus.swap_feito = swap_feito_q;
endmodule

// File: tb/tb_matriz_leds_varredura.sv
// Bench for matriz_leds_varredura: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a scan-position arithmetic model.
module tb_matriz_leds_varredura;
   localparam int NL = 7;
   localparam int NC = 5;
   localparam int DT = 8;
   localparam int BT = 2;
   localparam int BF = 2;
   localparam int FP = NC * DT;

   logic          clk = 1'b0;
   logic          reset, enable, wr_en, swap_req, pisca;
   logic [2:0]    wr_col;
   logic [NL-1:0] wr_data;
   logic [NL-1:0] linhas;
   logic [NC-1:0] colunas;
   logic          frame_fim, swap_pend, swap_feito;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   matriz_leds_varredura_if #(.N_LINHAS(NL), .N_COLUNAS(NC)) bus ();

   assign bus.enable   = enable;
   assign bus.wr_en    = wr_en;
   assign bus.wr_col   = wr_col;
   assign bus.wr_data  = wr_data;
   assign bus.swap_req = swap_req;
   assign bus.pisca    = pisca;
   assign linhas       = bus.linhas;
   assign colunas      = bus.colunas;
   assign frame_fim    = bus.frame_fim;
   assign swap_pend    = bus.swap_pend;
   assign swap_feito   = bus.swap_feito;

   matriz_leds_varredura #(
      .N_LINHAS(NL), .N_COLUNAS(NC), .DIV_TICKS(DT), .BLANK_TICKS(BT),
      .LINHA_ATIVA_BAIXA(1'b1), .BLINK_FRAMES(BF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Model: scan position from enabled-cycle count, buffers as named front/back arrays.
   int            s_cnt;
   int            frames_pisca;
   bit            m_pend;
   logic [NL-1:0] m_front [NC];
   logic [NL-1:0] m_back  [NC];
   logic [NL-1:0] e_lin;
   logic [NC-1:0] e_col;
   bit            e_ff, e_sf, e_sp;

   always @(posedge clk) begin
      int            tk, cl;
      bit            fe, pnow, vis;
      logic [NL-1:0] tmp;
      if (reset) begin
         s_cnt = 0;
         frames_pisca = 0;
         m_pend = 0;
         for (int i = 0; i < NC; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
         end
         e_lin = '1;
         e_col = '0;
         e_ff  = 0;
         e_sf  = 0;
         e_sp  = 0;
      end else begin
         tk   = s_cnt % DT;
         cl   = (s_cnt / DT) % NC;
         fe   = enable && (s_cnt % FP == FP - 1);
         pnow = m_pend || swap_req;
         vis  = enable && !(pisca && ((frames_pisca / BF) % 2 == 1)) && (tk >= BT);
         e_col = vis ? (5'(1) << cl) : '0;
         e_lin = '1;
         if (vis) begin
            for (int r = 0; r < NL; r++) e_lin[r] = ~m_front[cl][NL-1-r];
         end
         e_ff = fe;
         e_sf = fe && pnow;
         if (wr_en && wr_col < NC) m_back[wr_col] = wr_data;
         if (fe && pnow) begin
            for (int i = 0; i < NC; i++) begin
               tmp        = m_front[i];
               m_front[i] = m_back[i];
               m_back[i]  = tmp;
            end
            m_pend = 0;
         end else begin
            m_pend = pnow;
         end
         e_sp  = m_pend;
         s_cnt = enable ? s_cnt + 1 : 0;
         if (!enable || !pisca) frames_pisca = 0;
         else if (fe) frames_pisca++;
      end
      #1;
      n_tests++;
      if ({colunas, linhas, frame_fim, swap_feito, swap_pend} !== {e_col, e_lin, e_ff, e_sf, e_sp})
      begin
         n_fail++;
         $display("FAIL cycle_model t=%0t: colunas=%b linhas=%b ff=%b sf=%b sp=%b, expected %b %b %b %b %b",
                  $time, colunas, linhas, frame_fim, swap_feito, swap_pend,
                  e_col, e_lin, e_ff, e_sf, e_sp);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cols(input logic [NC-1:0] v, input string name);
      int k = 0;
      while (colunas !== v && k < 300) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(colunas), 32'(v));
   endtask

   task automatic wait_ff(input string name);
      int k = 0;
      while (frame_fim !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(frame_fim), 32'd1);
   endtask

   task automatic wait_sf(input string name);
      int k = 0;
      while (swap_feito !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(swap_feito), 32'd1);
   endtask

   task automatic write_col(input int c, input logic [NL-1:0] d);
      wr_en   = 1;
      wr_col  = 3'(c);
      wr_data = d;
      @(negedge clk);
      wr_en = 0;
   endtask

   logic [NC-1:0] s_col [81];
   logic [NL-1:0] s_lin [81];
   logic          s_ff  [81];
   logic [NL-1:0] bitmaps [NC];
   int            lit [3];
   int            n_sf;

   initial begin
      bitmaps = '{7'b0000100, 7'b0001100, 7'b1000101, 7'b1110001, 7'b1000011};
      reset = 1; enable = 0; wr_en = 0; wr_col = 0; wr_data = 0; swap_req = 0; pisca = 0;
      repeat (3) @(negedge clk);
      check("reset_colunas", 32'(colunas), 32'h0);
      check("reset_linhas", 32'(linhas), 32'h7F);
      check("reset_swap_pend", 32'(swap_pend), 32'h0);

      // 1: blank walk
      reset = 0; enable = 1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         s_col[k] = colunas;
         s_lin[k] = linhas;
         s_ff[k]  = frame_fim;
      end
      check("scan_k2_blank", 32'(s_col[2]), 32'h00);
      check("scan_k3_col0", 32'(s_col[3]), 32'h01);
      check("scan_k8_col0", 32'(s_col[8]), 32'h01);
      check("scan_k9_blank", 32'(s_col[9]), 32'h00);
      check("scan_k11_col1", 32'(s_col[11]), 32'h02);
      check("scan_k35_col4", 32'(s_col[35]), 32'h10);
      check("scan_linhas_dark", 32'(s_lin[3]), 32'h7F);
      check("frame_fim_k39", 32'(s_ff[39]), 32'h0);
      check("frame_fim_k40", 32'(s_ff[40]), 32'h1);
      check("frame_fim_k80", 32'(s_ff[80]), 32'h1);

      // 2: fill back buffer and swap
      for (int c = 0; c < NC; c++) write_col(c, bitmaps[c]);
      swap_req = 1;
      @(negedge clk);
      swap_req = 0;
      check("swap_pend_set", 32'(swap_pend), 32'h1);
      wait_sf("swap2_feito");
      wait_cols(5'b00001, "swap2_col0");
      check("swap2_linhas_col0", 32'(linhas), 32'b1101111);
      wait_cols(5'b00010, "swap2_col1");
      check("swap2_linhas_col1", 32'(linhas), 32'b1100111);
      wait_cols(5'b00100, "swap2_col2");
      check("swap2_linhas_col2", 32'(linhas), 32'b0101110);

      // 3: back writes invisible until swap; out-of-range column ignored
      for (int c = 0; c < NC; c++) write_col(c, (c == 2) ? 7'h7F : bitmaps[c]);
      write_col(6, 7'h2A);
      wait_cols(5'b00100, "t3_col2_pre");
      check("t3_col2_unchanged", 32'(linhas), 32'b0101110);
      swap_req = 1;
      @(negedge clk);
      swap_req = 0;
      wait_sf("t3_feito");
      wait_cols(5'b00001, "t3_col0");
      check("t3_col0_same", 32'(linhas), 32'b1101111);
      wait_cols(5'b00100, "t3_col2");
      check("t3_col2_all_lit", 32'(linhas), 32'h00);

      // 4: request in the exact frame-end cycle, then duplicate requests
      wait_ff("t4_ff");
      repeat (39) @(negedge clk);
      swap_req = 1;
      check("t4_pend_before", 32'(swap_pend), 32'h0);
      @(negedge clk);
      swap_req = 0;
      check("t4_feito_now", 32'(swap_feito), 32'h1);
      check("t4_ff_now", 32'(frame_fim), 32'h1);
      repeat (5) @(negedge clk);
      swap_req = 1;
      @(negedge clk);
      swap_req = 0;
      check("t4_pend_one", 32'(swap_pend), 32'h1);
      repeat (3) @(negedge clk);
      swap_req = 1;
      @(negedge clk);
      swap_req = 0;
      n_sf = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (swap_feito) n_sf++;
      end
      check("t4_single_swap", 32'(n_sf), 32'd1);

      // 5: blink
      wait_ff("t5_ff");
      pisca = 1;
      lit = '{0, 0, 0};
      for (int i = 1; i <= 91; i++) begin
         @(negedge clk);
         if (colunas != 0) lit[(i - 1) / FP]++;
      end
      check("t5_frame0_lit", 32'(lit[0]), 32'd30);
      check("t5_frame1_lit", 32'(lit[1]), 32'd30);
      check("t5_frame2_dark", 32'(lit[2]), 32'd0);
      pisca = 0;
      @(negedge clk);
      check("t5_unblink", 32'(colunas), 32'b00010);

      // 6: enable drop, restart, reset with pending swap
      wait_cols(5'b01000, "t6_col3");
      enable = 0;
      @(negedge clk);
      check("t6_dark", 32'(colunas), 32'h0);
      repeat (3) @(negedge clk);
      enable = 1;
      @(negedge clk);
      check("t6_re_blank1", 32'(colunas), 32'h0);
      @(negedge clk);
      check("t6_re_blank2", 32'(colunas), 32'h0);
      @(negedge clk);
      check("t6_re_col0", 32'(colunas), 32'h01);
      swap_req = 1;
      @(negedge clk);
      swap_req = 0;
      check("t6_pend", 32'(swap_pend), 32'h1);
      reset = 1;
      @(negedge clk);
      check("t6_rst_pend", 32'(swap_pend), 32'h0);
      check("t6_rst_col", 32'(colunas), 32'h0);
      check("t6_rst_lin", 32'(linhas), 32'h7F);
      reset = 0;

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         reset    = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 149) == 0) enable = ~enable;
         if ($urandom_range(0, 199) == 0) pisca = ~pisca;
         wr_en    = $urandom_range(0, 3) == 0;
         wr_col   = 3'($urandom_range(0, 7));
         wr_data  = 7'($urandom);
         swap_req = ($urandom_range(0, 29) == 0);
         @(negedge clk);
      end
      reset = 0; wr_en = 0; swap_req = 0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
